// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
//   - op encodings carried in instr[2:0]
//   - instruction bit positions
//   - issue controller FSM state type
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b111;
  localparam logic [2:0] OP_CMP_A = 3'b100;
  localparam logic [2:0] OP_CMP_B = 3'b101;
  localparam logic [2:0] OP_CMP_C = 3'b110;

  localparam int unsigned OP_LSB     = 0;
  localparam int unsigned FLOAT_BIT  = 3;
  localparam int unsigned SIGNED_BIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } stateT;

endpackage

// File: rtl/alu_op_legal.sv
// Combinational legality check and settle-count select for an ALU
// instruction. isSigned does not affect legality, so only instr[3:0] is taken.
//   instr    in  4  instruction bits [3:0]: [2:0] op, [3] isFloat
//   illegal  out 1  op 3'b010, or float compare (ops 100/101/110)
//   cntLoad  out 4  settle cycles minus one for this op
module alu_op_legal
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES     = 2,
  parameter int unsigned DIV_SETTLE_CYCLES = 4
) (
  input  logic [3:0] instr,
  output logic       illegal,
  output logic [3:0] cntLoad
);

  logic [2:0] op;
  logic       isFloat;

  assign op      = instr[OP_LSB +: 3];
  assign isFloat = instr[FLOAT_BIT];

  always_comb begin
    illegal = 1'b0;
    if (op == 3'b010) begin
      illegal = 1'b1;
    end else if (isFloat && (op == OP_CMP_A || op == OP_CMP_B || op == OP_CMP_C)) begin
      illegal = 1'b1;
    end
  end

  assign cntLoad = (op == OP_DIV) ? 4'(DIV_SETTLE_CYCLES - 1) : 4'(SETTLE_CYCLES - 1);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential initiator for the combinational 32-bit ALU. Accepts one request
// at a time, holds operands on the ALU inputs for a settle time, then returns
// the sampled result with its tag.
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_instr, req_tag request payload
//   alu_a, alu_b, alu_instr         registered ALU inputs
//   alu_s, alu_ze                   ALU result and zero-divide flag
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_ze, rsp_illegal, rsp_tag  response payload
//   busy                            not IDLE
//   op_count                        completed responses (wraps)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES     = 2,
  parameter int unsigned DIV_SETTLE_CYCLES = 4,
  parameter int unsigned TAG_W             = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [31:0]      req_instr,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_instr,
  input  logic [31:0]      alu_s,
  input  logic             alu_ze,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_ze,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      op_count
);

  stateT      state;
  stateT      stateNext;
  logic [3:0] cnt;
  logic [4:0] aluInstrQ;
  logic       reqIllegal;
  logic [3:0] reqCntLoad;
  logic       unusedInstrHi;

  assign unusedInstrHi = ^req_instr[31:5];

  alu_op_legal #(
    .SETTLE_CYCLES    (SETTLE_CYCLES),
    .DIV_SETTLE_CYCLES(DIV_SETTLE_CYCLES)
  ) uOpLegal (
    .instr  (req_instr[3:0]),
    .illegal(reqIllegal),
    .cntLoad(reqCntLoad)
  );

  // Gated by rst_n so every output reads 0 while reset is held.
  assign req_ready = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign alu_instr = {27'b0, aluInstrQ};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req_valid) stateNext = reqIllegal ? RESP : SETTLE;
      SETTLE:  if (cnt == '0) stateNext = RESP;
      RESP:    if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      aluInstrQ   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_ze      <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_tag     <= '0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_tag <= req_tag;
            if (reqIllegal) begin
              rsp_data    <= '0;
              rsp_ze      <= 1'b0;
              rsp_illegal <= 1'b1;
              rsp_valid   <= 1'b1;
            end else begin
              alu_a     <= req_a;
              alu_b     <= req_b;
              aluInstrQ <= req_instr[4:0];
              cnt       <= reqCntLoad;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_data    <= alu_s;
            rsp_ze      <= (aluInstrQ[OP_LSB +: 3] == OP_DIV) ? alu_ze : 1'b0;
            rsp_illegal <= 1'b0;
            rsp_valid   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b, req_instr;
  logic [3:0]  req_tag;
  logic [31:0] alu_a, alu_b, alu_instr;
  logic [31:0] alu_s;
  logic        alu_ze;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_ze, rsp_illegal;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lastAcc  = 0;
  logic zeForce = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple ALU environment model driven from the registered ALU inputs.
  always_comb begin
    alu_ze = zeForce;
    case (alu_instr[2:0])
      3'b000:  alu_s = alu_a + alu_b;
      3'b001:  alu_s = alu_a - alu_b;
      3'b011:  alu_s = alu_a * alu_b;
      3'b111: begin
        if (alu_b == 32'd0) begin
          alu_s  = 32'hFFFF_FFFF;
          alu_ze = 1'b1;
        end else begin
          alu_s = alu_a / alu_b;
        end
      end
      default: alu_s = {31'd0, alu_a < alu_b};
    endcase
  end

  alu_issue_ctrl #(
    .SETTLE_CYCLES    (2),
    .DIV_SETTLE_CYCLES(4),
    .TAG_W            (4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_instr(req_instr), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr),
    .alu_s(alu_s), .alu_ze(alu_ze),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ze(rsp_ze), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .busy(busy), .op_count(op_count)
  );

  // Present a request for one edge (called #1 after an edge, with DUT idle),
  // then scramble the payload so late sampling would be visible.
  task automatic accept(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] instr, input logic [3:0] tag);
    req_valid = 1'b1; req_a = a; req_b = b; req_instr = instr; req_tag = tag;
    @(posedge clk); #1;
    lastAcc   = cyc;
    req_valid = 1'b0;
    req_a = 32'hDEAD_BEEF; req_b = 32'hCAFE_F00D; req_instr = 32'h0000_0003; req_tag = 4'hF;
  endtask

  // Count edges after the accepting edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_instr = '0; req_tag = '0;
    #1;
    checks++; if ({alu_a, alu_b, alu_instr} !== 96'd0) begin failures++; $display("FAIL reset_alu got %h %h %h want 0", alu_a, alu_b, alu_instr); end
    checks++; if ({rsp_valid, rsp_ze, rsp_illegal, rsp_tag, rsp_data} !== 39'd0) begin failures++; $display("FAIL reset_rsp got v=%b d=%h want 0", rsp_valid, rsp_data); end
    checks++; if ({req_ready, busy, op_count} !== 18'd0) begin failures++; $display("FAIL reset_ctl got rdy=%b busy=%b cnt=%0d want 0", req_ready, busy, op_count); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_add;
    int lat;
    accept(32'd5, 32'd7, 32'h00, 4'h3);
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_instr !== 32'd0) begin failures++; $display("FAIL add_alu got %0d %0d %h want 5 7 0", alu_a, alu_b, alu_instr); end
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL add_busy got busy=%b rdy=%b want 1 0", busy, req_ready); end
    wait_rsp(lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got %0d want 2", lat); end
    checks++; if (rsp_data !== 32'd12 || rsp_ze !== 1'b0 || rsp_illegal !== 1'b0 || rsp_tag !== 4'h3) begin failures++; $display("FAIL add_rsp got d=%0d ze=%b il=%b tag=%h want 12 0 0 3", rsp_data, rsp_ze, rsp_illegal, rsp_tag); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd1 || req_ready !== 1'b1) begin failures++; $display("FAIL add_done got v=%b cnt=%0d rdy=%b want 0 1 1", rsp_valid, op_count, req_ready); end
  endtask

  task automatic test_div_zero;
    int lat;
    accept(32'd10, 32'd0, 32'h17, 4'h6);
    checks++; if (alu_instr !== 32'h17) begin failures++; $display("FAIL div0_instr got %h want 17", alu_instr); end
    wait_rsp(lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL div0_latency got %0d want 4", lat); end
    checks++; if (rsp_ze !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_tag !== 4'h6) begin failures++; $display("FAIL div0_rsp got ze=%b d=%h tag=%h want 1 ffffffff 6", rsp_ze, rsp_data, rsp_tag); end
    @(posedge clk); #1;
    checks++; if (op_count !== 16'd2) begin failures++; $display("FAIL div0_count got %0d want 2", op_count); end
  endtask

  task automatic test_ze_masked;
    int lat;
    zeForce = 1'b1;
    accept(32'd20, 32'd5, 32'hFFFF_FFE1, 4'h1);
    checks++; if (alu_instr !== 32'h01) begin failures++; $display("FAIL sub_instr got %h want 01", alu_instr); end
    wait_rsp(lat);
    checks++; if (lat !== 2 || rsp_data !== 32'd15 || rsp_ze !== 1'b0) begin failures++; $display("FAIL sub_ze got lat=%0d d=%0d ze=%b want 2 15 0", lat, rsp_data, rsp_ze); end
    @(posedge clk); #1;
    zeForce = 1'b0;
    checks++; if (op_count !== 16'd3) begin failures++; $display("FAIL sub_count got %0d want 3", op_count); end
  endtask

  task automatic test_illegal;
    logic [31:0] ill [2];
    ill[0] = 32'h02; ill[1] = 32'h0C;
    for (int unsigned i = 0; i < 2; i++) begin
      accept(32'd99, 32'd98, ill[i], 4'(i + 8));
      checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_data !== 32'd0 || rsp_ze !== 1'b0 || rsp_tag !== 4'(i + 8)) begin failures++; $display("FAIL illegal_rsp[%0d] got v=%b il=%b d=%h ze=%b tag=%h want 1 1 0 0 %h", i, rsp_valid, rsp_illegal, rsp_data, rsp_ze, rsp_tag, 4'(i + 8)); end
      checks++; if (alu_a !== 32'd20 || alu_b !== 32'd5 || alu_instr !== 32'h01) begin failures++; $display("FAIL illegal_alu[%0d] got %0d %0d %h want 20 5 01", i, alu_a, alu_b, alu_instr); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || op_count !== 16'(4 + i)) begin failures++; $display("FAIL illegal_count[%0d] got v=%b cnt=%0d want 0 %0d", i, rsp_valid, op_count, 4 + i); end
    end
  endtask

  task automatic test_float_div;
    int lat;
    accept(32'd9, 32'd3, 32'h0F, 4'h2);
    wait_rsp(lat);
    checks++; if (lat !== 4 || rsp_data !== 32'd3 || rsp_illegal !== 1'b0) begin failures++; $display("FAIL fdiv_rsp got lat=%0d d=%0d il=%b want 4 3 0", lat, rsp_data, rsp_illegal); end
    @(posedge clk); #1;
    checks++; if (op_count !== 16'd6) begin failures++; $display("FAIL fdiv_count got %0d want 6", op_count); end
  endtask

  task automatic test_backpressure;
    int lat;
    rsp_ready = 1'b0;
    accept(32'd6, 32'd7, 32'h03, 4'h9);
    wait_rsp(lat);
    checks++; if (lat !== 2 || rsp_data !== 32'd42) begin failures++; $display("FAIL bp_rsp got lat=%0d d=%0d want 2 42", lat, rsp_data); end
    req_valid = 1'b1; req_a = 32'd1; req_b = 32'd1; req_instr = 32'h00;
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd42 || rsp_tag !== 4'h9 || rsp_illegal !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL bp_hold[%0d] got v=%b d=%0d tag=%h rdy=%b want 1 42 9 0", i, rsp_valid, rsp_data, rsp_tag, req_ready); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== 16'd7 || alu_a !== 32'd6) begin failures++; $display("FAIL bp_release got v=%b rdy=%b cnt=%0d a=%0d want 0 1 7 6", rsp_valid, req_ready, op_count, alu_a); end
  endtask

  task automatic test_reset_mid;
    accept(32'd10, 32'd2, 32'h07, 4'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({alu_a, alu_b, alu_instr, rsp_data} !== 128'd0 || {rsp_valid, rsp_ze, rsp_illegal, rsp_tag} !== 7'd0) begin failures++; $display("FAIL rstmid_outs got a=%h i=%h v=%b want 0", alu_a, alu_instr, rsp_valid); end
    checks++; if ({busy, req_ready, op_count} !== 18'd0) begin failures++; $display("FAIL rstmid_ctl got busy=%b rdy=%b cnt=%0d want 0", busy, req_ready, op_count); end
    @(negedge clk); rst_n = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_quiet[%0d] got v=%b busy=%b want 0 0", i, rsp_valid, busy); end
    end
    checks++; if (op_count !== 16'd0 || req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_after got cnt=%0d rdy=%b want 0 1", op_count, req_ready); end
  endtask

  task automatic test_back_to_back;
    int lat, firstAcc;
    accept(32'd1, 32'd2, 32'h00, 4'h4);
    firstAcc = lastAcc;
    wait_rsp(lat);
    @(posedge clk); #1;
    accept(32'd30, 32'd4, 32'h01, 4'h5);
    checks++; if (lastAcc - firstAcc !== 4) begin failures++; $display("FAIL b2b_spacing got %0d want 4", lastAcc - firstAcc); end
    wait_rsp(lat);
    checks++; if (lat !== 2 || rsp_data !== 32'd26 || rsp_tag !== 4'h5) begin failures++; $display("FAIL b2b_rsp got lat=%0d d=%0d tag=%h want 2 26 5", lat, rsp_data, rsp_tag); end
    @(posedge clk); #1;
    checks++; if (op_count !== 16'd2) begin failures++; $display("FAIL b2b_count got %0d want 2", op_count); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_div_zero;
    test_ze_masked;
    test_illegal;
    test_float_div;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
